salsa20_rounds_seq: RTL



---
 rtl/salsa20_rounds_seq.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/salsa20_rounds_seq.sv
// Iterative Salsa20 core permutation: ROUNDS rounds, RPC rounds per clock.
// Optional feedforward (state + input) is enabled by defining SALSA20_FEEDFORWARD_EN.

module salsa20_quarter_round (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o,
    output logic [31:0] d_o
);
    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    logic [31:0] a1;
    logic [31:0] b1;
    logic [31:0] c1;
    logic [31:0] d1;

    // Each step consumes the word updated by the previous step.
    always_comb begin
        b1 = b ^ rotl(a + d, 7);
        c1 = c ^ rotl(b1 + a, 9);
        d1 = d ^ rotl(c1 + b1, 13);
        a1 = a ^ rotl(d1 + c1, 18);
    end

    assign a_o = a1;
    assign b_o = b1;
    assign c_o = c1;
    assign d_o = d1;
endmodule

module salsa20_round_stage (
    input  logic         is_row,
    input  logic [511:0] s_in,
    output logic [511:0] s_out
);
    // Tuple j of a round occupies slots 4j..4j+3 as (a,b,c,d).
    localparam int COL_IDX [16] = '{0, 4, 8, 12, 5, 9, 13, 1, 10, 14, 2, 6, 15, 3, 7, 11};
    localparam int ROW_IDX [16] = '{0, 1, 2, 3, 5, 6, 7, 4, 10, 11, 8, 9, 15, 12, 13, 14};

    logic [511:0] qr_in;
    logic [511:0] qr_out;

    always_comb begin
        qr_in = '0;
        for (int j = 0; j < 16; j++) begin
            if (is_row) qr_in[32*j +: 32] = s_in[32*ROW_IDX[j] +: 32];
            else        qr_in[32*j +: 32] = s_in[32*COL_IDX[j] +: 32];
        end
    end

    for (genvar q = 0; q < 4; q++) begin : g_qr
        salsa20_quarter_round u_qr (
            .a   (qr_in[32*(4*q+0) +: 32]),
            .b   (qr_in[32*(4*q+1) +: 32]),
            .c   (qr_in[32*(4*q+2) +: 32]),
            .d   (qr_in[32*(4*q+3) +: 32]),
            .a_o (qr_out[32*(4*q+0) +: 32]),
            .b_o (qr_out[32*(4*q+1) +: 32]),
            .c_o (qr_out[32*(4*q+2) +: 32]),
            .d_o (qr_out[32*(4*q+3) +: 32])
        );
    end

    // The four tuples partition all 16 words, so every word is rewritten.
    always_comb begin
        s_out = s_in;
        for (int j = 0; j < 16; j++) begin
            if (is_row) s_out[32*ROW_IDX[j] +: 32] = qr_out[32*j +: 32];
            else        s_out[32*COL_IDX[j] +: 32] = qr_out[32*j +: 32];
        end
    end
endmodule

module salsa20_rounds_seq #(
    parameter int ROUNDS = 20,
    parameter int RPC    = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] data_out,
    output logic         busy
);
    localparam int STEPS = ROUNDS / RPC;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    if ((ROUNDS % 2) != 0 || ROUNDS < 2 || ROUNDS > 20 || (RPC != 1 && RPC != 2)) begin : g_bad_params
        $error("salsa20_rounds_seq: ROUNDS must be even in 2..20 and RPC must be 1 or 2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t             fsm_state;
    logic [511:0]     state;
    logic [CNT_W-1:0] cnt;
    logic [511:0]     round_out;
    logic [511:0]     result;

    if (RPC == 1) begin : g_rpc1
        // Rounds alternate column/row, starting with a column round at cnt 0.
        salsa20_round_stage u_stage (
            .is_row (cnt[0]),
            .s_in   (state),
            .s_out  (round_out)
        );
    end else begin : g_rpc2
        logic [511:0] mid;
        salsa20_round_stage u_col (
            .is_row (1'b0),
            .s_in   (state),
            .s_out  (mid)
        );
        salsa20_round_stage u_row (
            .is_row (1'b1),
            .s_in   (mid),
            .s_out  (round_out)
        );
    end

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // in_ready is high only in IDLE, out_valid only in DONE, and data_out is
    // held stable from out_valid rising until the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_state <= IDLE;
            state     <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (fsm_state)
                IDLE: begin
                    if (in_valid) begin
                        state     <= data_in;
                        cnt       <= '0;
                        fsm_state <= RUN;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    state <= round_out;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        fsm_state <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_state <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    fsm_state <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef SALSA20_FEEDFORWARD_EN
    logic [511:0] orig;

    always_ff @(posedge clk) begin
        if (rst) begin
            orig <= '0;
        end else if (fsm_state == IDLE && in_valid) begin
            orig <= data_in;
        end
    end

    always_comb begin
        result = '0;
        for (int i = 0; i < 16; i++) begin
            result[32*i +: 32] = state[32*i +: 32] + orig[32*i +: 32];
        end
    end
`else
    assign result = state;
`endif

    assign data_out = out_valid ? result : '0;
endmodule
